// File: rtl/otter_dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache for the OTTER memory stage.
// Handles byte/half lane merging and load extension; moves whole 128-bit lines to BRAM.
module otter_dcache_ctrl #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned TAG_W   = 28 - INDEX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic [31:0] MEM_ADDR2,
    output logic        MEM_READ2,
    output logic        MEM_WRITE2,
    output logic [31:0] MEM_w0,
    output logic [31:0] MEM_w1,
    output logic [31:0] MEM_w2,
    output logic [31:0] MEM_w3,
    input  logic [31:0] MEM_r0,
    input  logic [31:0] MEM_r1,
    input  logic [31:0] MEM_r2,
    input  logic [31:0] MEM_r3
);
    localparam int unsigned LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_WB, S_FILL_REQ, S_FILL_WAIT, S_RESPOND
    } state_t;

    state_t state_q, state_d;

    logic [31:0]        data_q [LINES][4];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [31:0]        rdata_q;
    logic               done_q;
    logic               err_q;

    logic [1:0]         byte_off;
    logic [1:0]         word_off;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req_c, illegal_c, legal_c, hit_c;
    logic               access_c, fill_c, err_c;
    logic [31:0]        cur_word;

    assign byte_off = cpu_addr[1:0];
    assign word_off = cpu_addr[3:2];
    assign idx      = cpu_addr[3+INDEX_W:4];
    assign req_tag  = cpu_addr[31:4+INDEX_W];
    assign cur_word = data_q[idx][word_off];

    assign req_c     = cpu_rd | cpu_we;
    assign illegal_c = (cpu_rd & cpu_we) | (cpu_size == 2'd3)
                     | ((cpu_size == 2'd1) & byte_off[0])
                     | ((cpu_size == 2'd2) & (byte_off != 2'd0));
    assign legal_c   = req_c & ~illegal_c;
    assign hit_c     = valid_q[idx] & (tag_q[idx] == req_tag);

    // Load path: pick the addressed lane, then sign- or zero-extend.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] b, input logic zx);
        logic [7:0]  by;
        logic [15:0] hw;
        by = w[{b, 3'b000} +: 8];
        hw = b[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0:    return zx ? {24'd0, by} : {{24{by[7]}}, by};
            2'd1:    return zx ? {16'd0, hw} : {{16{hw[15]}}, hw};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] b);
        logic [31:0] r;
        r = old;
        case (sz)
            2'd0:    r[{b, 3'b000} +: 8] = wd[7:0];
            2'd1:    if (b[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (legal_c && !hit_c)
                             state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FILL_REQ;
            S_WB:        state_d = S_FILL_REQ;
            S_FILL_REQ:  state_d = S_FILL_WAIT;
            S_FILL_WAIT: state_d = S_RESPOND;
            S_RESPOND:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Bus strobes and control enables; all gated off in a reset cycle.
    always_comb begin
        MEM_READ2  = 1'b0;
        MEM_WRITE2 = 1'b0;
        MEM_ADDR2  = 32'd0;
        MEM_w0     = 32'd0;
        MEM_w1     = 32'd0;
        MEM_w2     = 32'd0;
        MEM_w3     = 32'd0;
        access_c   = 1'b0;
        fill_c     = 1'b0;
        err_c      = 1'b0;
        cpu_stall  = 1'b0;
        if (!RST) begin
            MEM_READ2  = (state_q == S_FILL_REQ);
            MEM_WRITE2 = (state_q == S_WB);
            fill_c     = (state_q == S_FILL_WAIT);
            access_c   = ((state_q == S_IDLE) && legal_c && hit_c) || (state_q == S_RESPOND);
            err_c      = (state_q == S_IDLE) && req_c && illegal_c;
            cpu_stall  = (state_q != S_IDLE) || (legal_c && !hit_c);
            if (MEM_WRITE2) begin
                MEM_ADDR2 = {tag_q[idx], idx, 4'b0000};
                MEM_w0    = data_q[idx][0];
                MEM_w1    = data_q[idx][1];
                MEM_w2    = data_q[idx][2];
                MEM_w3    = data_q[idx][3];
            end else if (MEM_READ2) begin
                MEM_ADDR2 = {req_tag, idx, 4'b0000};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_c) begin
            data_q[idx][0] <= MEM_r0;
            data_q[idx][1] <= MEM_r1;
            data_q[idx][2] <= MEM_r2;
            data_q[idx][3] <= MEM_r3;
            tag_q[idx]     <= req_tag;
        end else if (access_c && cpu_we) begin
            data_q[idx][word_off] <= store_merge(cur_word, cpu_wdata, cpu_size, byte_off);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_c) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (access_c && cpu_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= access_c;
            err_q  <= err_c;
            if (access_c && cpu_rd)
                rdata_q <= load_ext(cur_word, cpu_size, byte_off, cpu_sign);
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
endmodule

// File: tb/tb_otter_dcache_ctrl.sv
// Directed bench for otter_dcache_ctrl with a small line-wide BRAM model.
module tb_otter_dcache_ctrl;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rd, cpu_we, cpu_sign, cpu_done, cpu_stall, cpu_err;
    logic [1:0]  cpu_size;
    logic [31:0] MEM_ADDR2, MEM_w0, MEM_w1, MEM_w2, MEM_w3;
    logic [31:0] MEM_r0, MEM_r1, MEM_r2, MEM_r3;
    logic        MEM_READ2, MEM_WRITE2;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];
    int          rd_cnt = 0, wr_cnt = 0, cyc = 0, rd_cyc = 0, wr_cyc = 0;
    logic [31:0] rd_addr, wr_addr;
    logic [31:0] wr_w [4];

    always #5 CLK = ~CLK;

    otter_dcache_ctrl dut (
        .CLK(CLK), .RST(RST),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_we(cpu_we),
        .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .MEM_ADDR2(MEM_ADDR2), .MEM_READ2(MEM_READ2), .MEM_WRITE2(MEM_WRITE2),
        .MEM_w0(MEM_w0), .MEM_w1(MEM_w1), .MEM_w2(MEM_w2), .MEM_w3(MEM_w3),
        .MEM_r0(MEM_r0), .MEM_r1(MEM_r1), .MEM_r2(MEM_r2), .MEM_r3(MEM_r3)
    );

    // BRAM line port: read data appears the cycle after the strobe, writes land at the edge.
    always @(posedge CLK) begin
        logic [9:0] wa;
        cyc++;
        wa = MEM_ADDR2[11:2];
        if (MEM_READ2) begin
            rd_cnt++;
            rd_cyc  = cyc;
            rd_addr = MEM_ADDR2;
            MEM_r0 <= mem[wa];
            MEM_r1 <= mem[wa + 10'd1];
            MEM_r2 <= mem[wa + 10'd2];
            MEM_r3 <= mem[wa + 10'd3];
        end
        if (MEM_WRITE2) begin
            wr_cnt++;
            wr_cyc  = cyc;
            wr_addr = MEM_ADDR2;
            wr_w[0] = MEM_w0; wr_w[1] = MEM_w1; wr_w[2] = MEM_w2; wr_w[3] = MEM_w3;
            mem[wa]         = MEM_w0;
            mem[wa + 10'd1] = MEM_w1;
            mem[wa + 10'd2] = MEM_w2;
            mem[wa + 10'd3] = MEM_w3;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU access held until done or err; reports cycles from request edge to response.
    task automatic access(input logic rd, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                          output int cycles, output logic [31:0] data,
                          output logic err, output logic stall0);
        logic fin;
        cpu_rd = rd; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_size = sz; cpu_sign = sg;
        #1;
        stall0 = cpu_stall;
        cycles = 0; fin = 1'b0; err = 1'b0; data = 32'd0;
        for (int i = 0; i < 20 && !fin; i++) begin
            @(posedge CLK); #1;
            cycles++;
            if (!MEM_READ2 && !MEM_WRITE2)
                chk("idle_bus", MEM_ADDR2 | MEM_w0 | MEM_w1 | MEM_w2 | MEM_w3, 32'd0);
            if (cpu_done || cpu_err) begin
                fin = 1'b1; err = cpu_err; data = cpu_rdata;
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        cpu_rd = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        int          n, r0, w0;
        logic [31:0] d;
        logic        e, s0;

        RST = 1'b1; cpu_rd = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        cpu_size = 2'd2; cpu_sign = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h104 >> 2] = 32'h8001FF7F;
        mem[32'h108 >> 2] = 32'h11223344;
        mem[32'h10C >> 2] = 32'h55667788;
        mem[32'h110 >> 2] = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) mem[(32'h200 >> 2) + i] = 32'hCAFE0000 + 32'(i);

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_done", {31'd0, cpu_done}, 32'd0);
        chk("rst_err", {31'd0, cpu_err}, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_rd2", {31'd0, MEM_READ2}, 32'd0);
        RST = 1'b0;

        // Cold load: clean miss, then a hit on the same word.
        r0 = rd_cnt; w0 = wr_cnt;
        access(1, 0, 32'h100, 0, 2'd2, 0, n, d, e, s0);
        chk("miss_stall0", {31'd0, s0}, 32'd1);
        chk("miss_data", d, 32'hDEADBEEF);
        chk("miss_cycles", 32'(n), 32'd4);
        chk("miss_reads", 32'(rd_cnt - r0), 32'd1);
        chk("miss_rdaddr", rd_addr, 32'h100);
        chk("miss_writes", 32'(wr_cnt - w0), 32'd0);
        r0 = rd_cnt;
        access(1, 0, 32'h100, 0, 2'd2, 0, n, d, e, s0);
        chk("hit_stall0", {31'd0, s0}, 32'd0);
        chk("hit_data", d, 32'hDEADBEEF);
        chk("hit_cycles", 32'(n), 32'd1);
        chk("hit_reads", 32'(rd_cnt - r0), 32'd0);

        // Subword loads on 0x8001_FF7F.
        access(1, 0, 32'h104, 0, 2'd0, 0, n, d, e, s0); chk("lb_b0", d, 32'h0000007F);
        access(1, 0, 32'h105, 0, 2'd0, 0, n, d, e, s0); chk("lb_b1", d, 32'hFFFFFFFF);
        access(1, 0, 32'h106, 0, 2'd1, 1, n, d, e, s0); chk("lhu_b2", d, 32'h00008001);
        access(1, 0, 32'h106, 0, 2'd1, 0, n, d, e, s0); chk("lh_b2", d, 32'hFFFF8001);
        access(1, 0, 32'h105, 0, 2'd0, 1, n, d, e, s0); chk("lbu_b1", d, 32'h000000FF);
        chk("lbu_cycles", 32'(n), 32'd1);

        // Store byte hit, then read the merged word back.
        w0 = wr_cnt;
        access(0, 1, 32'h105, 32'h000000AB, 2'd0, 0, n, d, e, s0);
        chk("sb_cycles", 32'(n), 32'd1);
        access(1, 0, 32'h104, 0, 2'd2, 0, n, d, e, s0);
        chk("sb_merge", d, 32'h8001AB7F);
        chk("sb_nowrite", 32'(wr_cnt - w0), 32'd0);

        // Illegal requests.
        r0 = rd_cnt; w0 = wr_cnt;
        access(1, 0, 32'h101, 0, 2'd1, 0, n, d, e, s0);
        chk("ill_lh_err", {31'd0, e}, 32'd1);
        chk("ill_lh_cycles", 32'(n), 32'd1);
        chk("ill_lh_stall0", {31'd0, s0}, 32'd0);
        @(posedge CLK); #1;
        chk("ill_err_pulse", {31'd0, cpu_err}, 32'd0);
        access(1, 1, 32'h100, 32'h12345678, 2'd2, 0, n, d, e, s0);
        chk("ill_rdwe_err", {31'd0, e}, 32'd1);
        chk("ill_strobes", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
        access(1, 0, 32'h100, 0, 2'd2, 0, n, d, e, s0);
        chk("ill_tag_kept", 32'(n), 32'd1);
        chk("ill_data_kept", d, 32'hDEADBEEF);

        // Dirty eviction: 0x200 maps to the same index as the dirty 0x100 line.
        r0 = rd_cnt; w0 = wr_cnt;
        access(1, 0, 32'h200, 0, 2'd2, 0, n, d, e, s0);
        chk("ev_cycles", 32'(n), 32'd5);
        chk("ev_data", d, 32'hCAFE0000);
        chk("ev_writes", 32'(wr_cnt - w0), 32'd1);
        chk("ev_reads", 32'(rd_cnt - r0), 32'd1);
        chk("ev_wraddr", wr_addr, 32'h100);
        chk("ev_w0", wr_w[0], 32'hDEADBEEF);
        chk("ev_w1", wr_w[1], 32'h8001AB7F);
        chk("ev_w2", wr_w[2], 32'h11223344);
        chk("ev_w3", wr_w[3], 32'h55667788);
        chk("ev_rdaddr", rd_addr, 32'h200);
        chk("ev_order", 32'(wr_cyc + 1), 32'(rd_cyc));
        w0 = wr_cnt;
        access(1, 0, 32'h104, 0, 2'd2, 0, n, d, e, s0);
        chk("rt_data", d, 32'h8001AB7F);
        chk("rt_cycles", 32'(n), 32'd4);
        chk("rt_clean", 32'(wr_cnt - w0), 32'd0);
        access(1, 0, 32'h110, 0, 2'd2, 0, n, d, e, s0);
        chk("l1_data", d, 32'h0BADF00D);

        // Reset while the fill is outstanding.
        cpu_rd = 1'b1; cpu_addr = 32'h200; cpu_size = 2'd2; cpu_sign = 1'b0;
        #1;
        chk("rm_stall0", {31'd0, cpu_stall}, 32'd1);
        @(posedge CLK); #1;
        chk("rm_fillreq", {31'd0, MEM_READ2}, 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1; cpu_rd = 1'b0;
        #1;
        chk("rm_rst_stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("rm_done", {31'd0, cpu_done}, 32'd0);
        chk("rm_stall", {31'd0, cpu_stall}, 32'd0);
        r0 = rd_cnt;
        access(1, 0, 32'h110, 0, 2'd2, 0, n, d, e, s0);
        chk("rm_inval_cycles", 32'(n), 32'd4);
        chk("rm_inval_reads", 32'(rd_cnt - r0), 32'd1);
        r0 = rd_cnt;
        access(1, 0, 32'h200, 0, 2'd2, 0, n, d, e, s0);
        chk("rm_refetch", 32'(rd_cnt - r0), 32'd1);
        chk("rm_data", d, 32'hCAFE0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
